// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Boot-time writer for the core's instruction memory. A byte stream arrives
//   on a valid/ready link. Each frame is a 16-bit little-endian word count
//   followed by that many little-endian 32-bit instruction words. The words
//   are written to consecutive imem word addresses, starting at BASE_ADDR.
//   The core is held in reset until the whole frame has been consumed.
//
// Parameters:
//   ADDR_WIDTH   imem word-address width; capacity is 2**ADDR_WIDTH words
//   BASE_ADDR    first imem word address written
//
// Ports:
//   clk            core clock; every state update happens on posedge
//   reset_n        asynchronous, active-low reset
//   in_valid       byte-stream data valid
//   in_data        byte-stream data
//   in_ready       a byte transfers when in_valid & in_ready
//   start          re-arm pulse; only honoured once the load is done
//   mem_we         imem write strobe, one cycle per written word
//   mem_addr       imem word address
//   mem_wdata      imem write data
//   core_reset_n   active-low reset to the core; low while loading
//   done           load complete
//   overflow       sticky: the frame held more words than fit above BASE_ADDR
//   words_loaded   number of words actually written in the current frame
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_reset_n,
    output logic                  done,
    output logic                  overflow,
    output logic [15:0]           words_loaded
);

    // Number of words that fit between BASE_ADDR and the top of imem.
    // Kept one bit wider than the index so a full 16-bit address space
    // can still be represented.
    localparam logic [16:0] CAPACITY = 17'((1 << ADDR_WIDTH) - BASE_ADDR);

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        WRITE,
        DONE
    } state_t;

    state_t                  state_q,        state_d;
    logic [15:0]             count_q,        count_d;
    logic [15:0]             index_q,        index_d;
    logic [1:0]              byte_idx_q,     byte_idx_d;
    logic [31:0]             word_q,         word_d;
    logic                    ready_q,        ready_d;
    logic                    mem_we_q,       mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,     mem_addr_d;
    logic [31:0]             mem_wdata_q,    mem_wdata_d;
    logic                    core_rst_n_q,   core_rst_n_d;
    logic                    done_q,         done_d;
    logic                    overflow_q,     overflow_d;
    logic [15:0]             words_loaded_q, words_loaded_d;

    logic                    accept;
    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   target_addr;

    // in_ready is registered so it is low throughout reset and only rises
    // on the first clock edge after release.
    assign accept   = in_valid & ready_q;

    // Decided while the last byte of a word arrives, so the strobe can be
    // registered and appear in the single WRITE cycle.
    assign in_range    = ({1'b0, index_q} < CAPACITY);
    assign target_addr = ADDR_WIDTH'(32'(BASE_ADDR) + 32'(index_q));

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= CNT_LO;
            count_q        <= '0;
            index_q        <= '0;
            byte_idx_q     <= '0;
            word_q         <= '0;
            ready_q        <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= ADDR_WIDTH'(BASE_ADDR);
            mem_wdata_q    <= '0;
            core_rst_n_q   <= 1'b0;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            index_q        <= index_d;
            byte_idx_q     <= byte_idx_d;
            word_q         <= word_d;
            ready_q        <= ready_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            core_rst_n_q   <= core_rst_n_d;
            done_q         <= done_d;
            overflow_q     <= overflow_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        index_d        = index_q;
        byte_idx_d     = byte_idx_q;
        word_d         = word_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        overflow_d     = overflow_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            CNT_LO: begin
                if (accept) begin
                    count_d = {count_q[15:8], in_data};
                    state_d = CNT_HI;
                end
            end

            CNT_HI: begin
                if (accept) begin
                    count_d = {in_data, count_q[7:0]};
                    if ({in_data, count_q[7:0]} == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d = {word_q[31:8],  in_data};
                        2'd1: word_d = {word_q[31:16], in_data, word_q[7:0]};
                        2'd2: word_d = {word_q[31:24], in_data, word_q[15:0]};
                        default: begin
                            word_d  = {in_data, word_q[23:0]};
                            state_d = WRITE;
                            // Words past the top of imem are consumed but
                            // never written, so the address can never wrap.
                            if (in_range) begin
                                mem_we_d    = 1'b1;
                                mem_addr_d  = target_addr;
                                mem_wdata_d = {in_data, word_q[23:0]};
                            end
                        end
                    endcase
                end
            end

            WRITE: begin
                if (mem_we_q) begin
                    words_loaded_d = words_loaded_q + 16'd1;
                end else begin
                    overflow_d = 1'b1;
                end
                index_d = index_q + 16'd1;
                if ((index_q + 16'd1) == count_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                end
            end

            DONE: begin
                if (start) begin
                    state_d        = CNT_LO;
                    count_d        = '0;
                    index_d        = '0;
                    byte_idx_d     = '0;
                    overflow_d     = 1'b0;
                    words_loaded_d = '0;
                end
            end

            default: begin
                state_d = CNT_LO;
            end
        endcase

        ready_d      = (state_d == CNT_LO) || (state_d == CNT_HI) || (state_d == DATA);
        done_d       = (state_d == DONE);
        core_rst_n_d = (state_d == DONE);
    end

    assign in_ready     = ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_reset_n = core_rst_n_q;
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//
// Two loaders share one byte stream: dutA has the full 256-word imem and
// dutB only four words, so the same frame exercises both the normal path
// and the overflow path. Each write strobe is logged into a per-instance
// queue as {address, data}.
// ----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk;
    logic        reset_n;
    logic        inValid;
    logic [7:0]  inData;
    logic        start;

    logic        aReady,  bReady;
    logic        aWe,     bWe;
    logic [7:0]  aAddr;
    logic [1:0]  bAddr;
    logic [31:0] aWdata,  bWdata;
    logic        aCoreRstN, bCoreRstN;
    logic        aDone,   bDone;
    logic        aOvf,    bOvf;
    logic [15:0] aLoaded, bLoaded;

    logic [47:0] wrA[$];
    logic [47:0] wrB[$];
    int          readyInWrite;

    int          passCount;
    int          totalCount;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] expWord;
    } vector_t;

    vector_t vectors[4];

    imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dutA (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (inValid),
        .in_data      (inData),
        .in_ready     (aReady),
        .start        (start),
        .mem_we       (aWe),
        .mem_addr     (aAddr),
        .mem_wdata    (aWdata),
        .core_reset_n (aCoreRstN),
        .done         (aDone),
        .overflow     (aOvf),
        .words_loaded (aLoaded)
    );

    imem_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dutB (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (inValid),
        .in_data      (inData),
        .in_ready     (bReady),
        .start        (start),
        .mem_we       (bWe),
        .mem_addr     (bAddr),
        .mem_wdata    (bWdata),
        .core_reset_n (bCoreRstN),
        .done         (bDone),
        .overflow     (bOvf),
        .words_loaded (bLoaded)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Write logger: records every strobe and flags ready high in a write cycle.
    always @(posedge clk) begin
        if (aWe) begin
            wrA.push_back({8'h00, aAddr, aWdata});
            if (aReady) readyInWrite++;
        end
        if (bWe) begin
            wrB.push_back({14'h0000, bAddr, bWdata});
            if (bReady) readyInWrite++;
        end
    end

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one byte and hold it until dutA accepts it (bounded).
    task automatic applyStimulus(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        inValid = 1'b1;
        inData  = b;
        while (!aReady && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            checkOutput("byteAcceptTimeout", 48'(waited), 48'd0);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        inValid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic waitDone(input string name);
        int waited;
        waited = 0;
        @(negedge clk);
        inValid = 1'b0;
        while (!aDone && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput(name, 48'(aDone), 48'd1);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        applyStimulus(w[7:0]);
        applyStimulus(w[15:8]);
        applyStimulus(w[23:16]);
        applyStimulus(w[31:24]);
    endtask

    initial begin
        passCount    = 0;
        totalCount   = 0;
        readyInWrite = 0;
        inValid      = 1'b0;
        inData       = 8'h00;
        start        = 1'b0;
        reset_n      = 1'b0;

        vectors[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678};
        vectors[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
        vectors[2] = '{8'h00, 8'h00, 8'h00, 8'h80, 32'h80000000};
        vectors[3] = '{8'h01, 8'h00, 8'h00, 8'h00, 32'h00000001};

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        checkOutput("rstReady",    48'(aReady),    48'd0);
        checkOutput("rstCoreRstN", 48'(aCoreRstN), 48'd0);
        checkOutput("rstDone",     48'(aDone),     48'd0);
        checkOutput("rstWe",       48'(aWe),       48'd0);
        checkOutput("rstAddr",     48'(aAddr),     48'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterRst", 48'(aReady), 48'd1);

        // Two-word frame, continuous valid.
        wrA.delete();
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        sendWord(32'h00000013);
        sendWord(32'h00100113);
        waitDone("frame2Done");
        checkOutput("frame2Writes", 48'(wrA.size()), 48'd2);
        if (wrA.size() == 2) begin
            checkOutput("frame2W0", wrA[0], {16'h0000, 32'h00000013});
            checkOutput("frame2W1", wrA[1], {16'h0001, 32'h00100113});
        end
        checkOutput("frame2Loaded",   48'(aLoaded),    48'd2);
        checkOutput("frame2CoreRstN", 48'(aCoreRstN),  48'd1);
        checkOutput("frame2ReadyDone", 48'(aReady),    48'd0);
        checkOutput("readyInWrite",   48'(readyInWrite), 48'd0);

        // Start re-arms the loader.
        pulseStart();
        checkOutput("startDone",     48'(aDone),     48'd0);
        checkOutput("startCoreRstN", 48'(aCoreRstN), 48'd0);
        checkOutput("startReady",    48'(aReady),    48'd1);

        // Zero-length frame.
        wrA.delete();
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        waitDone("zeroDone");
        checkOutput("zeroWrites", 48'(wrA.size()), 48'd0);
        checkOutput("zeroLoaded", 48'(aLoaded),    48'd0);

        // Start while not done is ignored; in_valid in DONE is not consumed.
        pulseStart();
        wrA.delete();
        applyStimulus(8'h01);
        @(negedge clk);
        inValid = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        checkOutput("startIgnored", 48'(aReady), 48'd1);
        applyStimulus(8'h00);
        // Gap of five cycles between bytes 2 and 3 of the word.
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        idle(5);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        waitDone("gapDone");
        checkOutput("gapWrites", 48'(wrA.size()), 48'd1);
        if (wrA.size() == 1) begin
            checkOutput("gapWord", wrA[0], {16'h0000, 32'h44332211});
        end
        @(negedge clk);
        inValid = 1'b1;
        inData  = 8'hAA;
        repeat (3) @(negedge clk);
        inValid = 1'b0;
        checkOutput("doneIgnoresValid", 48'(aLoaded), 48'd1);

        // Single-word frames from the vector table.
        for (int i = 0; i < 4; i++) begin
            pulseStart();
            wrA.delete();
            applyStimulus(8'h01);
            applyStimulus(8'h00);
            applyStimulus(vectors[i].b0);
            applyStimulus(vectors[i].b1);
            applyStimulus(vectors[i].b2);
            applyStimulus(vectors[i].b3);
            waitDone($sformatf("vecDone%0d", i));
            checkOutput($sformatf("vecWrites%0d", i), 48'(wrA.size()), 48'd1);
            if (wrA.size() == 1) begin
                checkOutput($sformatf("vecWord%0d", i), wrA[0], {16'h0000, vectors[i].expWord});
            end
        end

        // Five-word frame: dutB only holds four words.
        pulseStart();
        wrA.delete();
        wrB.delete();
        applyStimulus(8'h05);
        applyStimulus(8'h00);
        for (int i = 0; i < 5; i++) begin
            sendWord(32'hA0000000 | 32'(i));
        end
        waitDone("ovfDone");
        checkOutput("ovfBDone",    48'(bDone),       48'd1);
        checkOutput("ovfBFlag",    48'(bOvf),        48'd1);
        checkOutput("ovfBLoaded",  48'(bLoaded),     48'd4);
        checkOutput("ovfBWrites",  48'(wrB.size()),  48'd4);
        if (wrB.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("ovfBWord%0d", i), wrB[i], {16'(i), 32'hA0000000 | 32'(i)});
            end
        end
        checkOutput("ovfAFlag",   48'(aOvf),    48'd0);
        checkOutput("ovfALoaded", 48'(aLoaded), 48'd5);

        // Start clears the sticky overflow.
        pulseStart();
        checkOutput("ovfCleared", 48'(bOvf), 48'd0);

        // Reset in the middle of a load, after six data bytes.
        wrA.delete();
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'h50 + 8'(i));
        end
        @(negedge clk);
        inValid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midRstReady",  48'(aReady),  48'd0);
        checkOutput("midRstLoaded", 48'(aLoaded), 48'd0);
        checkOutput("midRstWrites", 48'(wrA.size()), 48'd1);
        reset_n = 1'b1;
        @(negedge clk);
        wrA.delete();
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'hEF);
        applyStimulus(8'hBE);
        applyStimulus(8'hAD);
        applyStimulus(8'hDE);
        waitDone("freshDone");
        checkOutput("freshWrites", 48'(wrA.size()), 48'd1);
        if (wrA.size() == 1) begin
            checkOutput("freshWord", wrA[0], {16'h0000, 32'hDEADBEEF});
        end
        pulseStart();
        checkOutput("finalCoreRstN", 48'(aCoreRstN), 48'd0);
        checkOutput("finalDone",     48'(aDone),     48'd0);
        checkOutput("finalReady",    48'(aReady),    48'd1);
        checkOutput("finalReadyInWrite", 48'(readyInWrite), 48'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
